// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer and flush.
// Optional saturating stall counter on STALL_COUNT when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]           STALL_COUNT
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  state;
  occ_t                  state_next;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] main_next;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH-1:0] skid_next;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  in_ready_next;
  logic                  out_valid_next;
  logic                  accept;
  logic                  take;

  // Occupancy next-state and data steering; handshake flags are registered copies of state.
  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    accept     = IN_VALID & in_ready_q;
    take       = out_valid_q & OUT_READY;
    if (FLUSH) begin
      state_next = EMPTY;
      main_next  = RESET_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = IN_DATA;
          end else begin
            state_next = EMPTY;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_next = IN_DATA;
          end else if (accept) begin
            state_next = TWO;
            skid_next  = IN_DATA;
          end else if (take) begin
            state_next = EMPTY;
            main_next  = RESET_VALUE;
          end else begin
            state_next = ONE;
          end
        end
        TWO: begin
          if (take) begin
            state_next = ONE;
            main_next  = skid_data;
          end else begin
            state_next = TWO;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = RESET_VALUE;
        end
      endcase
    end
    in_ready_next  = (state_next != TWO);
    out_valid_next = (state_next != EMPTY);
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= EMPTY;
      main_data   <= RESET_VALUE;
      skid_data   <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      main_data   <= main_next;
      skid_data   <= skid_next;
      in_ready_q  <= in_ready_next;
      out_valid_q <= out_valid_next;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = main_data;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_count;

  // Saturating count of cycles where the head is held by downstream; FLUSH does not clear it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_count <= 32'd0;
    end else if (out_valid_q && !OUT_READY && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

  assign STALL_COUNT = stall_count;
`endif

endmodule
